// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU datapath types and helpers: datapath width,
//                serial-adder state encoding and per-bit generate/propagate.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Native datapath width of the ALU
  localparam int DATA_W = 32;

  // Serial adder control states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } adder_state_t;

  // Per-bit generate/propagate pair, returned as {g, p}
  function automatic logic [1:0] bit_gp(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_slice.sv
// ============================================================================
//  Module      : cla_slice
//  Description : Combinational BPC-bit carry-look-ahead adder slice. Every
//                internal carry is expanded directly from generate/propagate
//                terms, so there is no ripple chain inside the digit.
//                c_msb is the carry into the slice MSB (used for overflow).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_slice
  import alu_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic [BPC-1:0] x,
  input  logic [BPC-1:0] y,
  input  logic           ci,
  output logic [BPC-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [BPC-1:0] w_g;
  logic [BPC-1:0] w_p;
  logic [BPC:0]   w_c;

  for (genvar i = 0; i < BPC; i++) begin : g_gp
    logic [1:0] w_gp;
    assign w_gp   = bit_gp(x[i], y[i]);
    assign w_g[i] = w_gp[1];
    assign w_p[i] = w_gp[0];
  end

  // Look-ahead: c[i] = ci&p[0..i-1] | OR_j( g[j] & p[j+1..i-1] )
  always_comb begin
    logic w_acc;
    logic w_term;
    w_c    = '0;
    w_acc  = 1'b0;
    w_term = 1'b0;
    for (int i = 0; i <= BPC; i++) begin
      w_acc = ci;
      for (int j = 0; j < i; j++) begin
        w_acc = w_acc & w_p[j];
      end
      for (int j = 0; j < i; j++) begin
        w_term = w_g[j];
        for (int k = j + 1; k < i; k++) begin
          w_term = w_term & w_p[k];
        end
        w_acc = w_acc | w_term;
      end
      w_c[i] = w_acc;
    end
  end

  assign s     = w_p ^ w_c[BPC-1:0];
  assign co    = w_c[BPC];
  assign c_msb = w_c[BPC-1];

endmodule

`default_nettype wire

// File: rtl/serial_cla_adder.sv
// ============================================================================
//  Module      : serial_cla_adder
//  Description : Multi-cycle adder. Adds WIDTH-bit a + b + cin one BPC-bit
//                digit per clock, LSB digit first, each digit formed by a
//                cla_slice. start/busy/done handshake; result and carry-out
//                hold until the next accepted start.
//                Optional feature macro ADDER_OVERFLOW_FLAG_EN adds the
//                signed-overflow output ovf.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int BPC   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0]       C_ST_IDLE = IDLE;
  localparam logic [0:0]       C_ST_RUN  = RUN;
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(N - 1);

  if (WIDTH % BPC != 0) begin : g_cfg_check
    $error("serial_cla_adder: WIDTH (%0d) must be a multiple of BPC (%0d)", WIDTH, BPC);
  end

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;

  logic [BPC-1:0]   w_a_dig;
  logic [BPC-1:0]   w_b_dig;
  logic [BPC-1:0]   w_s;
  logic             w_co;
  logic             w_cmsb;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == C_ST_IDLE) && start;
  assign w_last   = (r_cnt == C_LAST);

  // Select the operand digit addressed by the counter
  always_comb begin
    w_a_dig = r_a[int'(r_cnt) * BPC +: BPC];
    w_b_dig = r_b[int'(r_cnt) * BPC +: BPC];
  end

  cla_slice #(
    .BPC (BPC)
  ) u_slice (
    .x     (w_a_dig),
    .y     (w_b_dig),
    .ci    (r_carry),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_cmsb)
  );

  // Control FSM, digit counter, operand capture and result accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        C_ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_state <= C_ST_RUN;
          end
        end
        C_ST_RUN: begin
          r_sum[int'(r_cnt) * BPC +: BPC] <= w_s;
          r_carry <= w_co;
          if (w_last) begin
            r_state <= C_ST_IDLE;
            r_done  <= 1'b1;
            r_cout  <= w_co;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

`ifdef ADDER_OVERFLOW_FLAG_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if ((r_state == C_ST_RUN) && w_last) begin
      r_ovf <= w_co ^ w_cmsb;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_cmsb;
  assign w_unused_cmsb = w_cmsb ^ w_accept;
`endif

  assign busy = (r_state == C_ST_RUN);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_cla_adder.sv
// ============================================================================
//  Module      : tb_serial_cla_adder
//  Description : Self-checking bench for serial_cla_adder. Directed vectors
//                on a BPC=4 instance, then random vectors driven to BPC=1,
//                4 and 32 instances in parallel, compared to a + b + cin.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;

  logic        busy1, done1, cout1;
  logic        busy4, done4, cout4;
  logic        busy32, done32, cout32;
  logic [31:0] sum1, sum4, sum32;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic        ovf1, ovf4, ovf32;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_cla_adder #(.WIDTH(32), .BPC(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef ADDER_OVERFLOW_FLAG_EN
    , .ovf(ovf1)
`endif
  );

  serial_cla_adder #(.WIDTH(32), .BPC(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef ADDER_OVERFLOW_FLAG_EN
    , .ovf(ovf4)
`endif
  );

  serial_cla_adder #(.WIDTH(32), .BPC(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
`ifdef ADDER_OVERFLOW_FLAG_EN
    , .ovf(ovf32)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge; returns cycles until done4 (-1 on timeout)
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done4) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_add(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                         output int lat);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int          lat;
    int          npulse;
    logic        busy_ok;
    logic        s1, s4, s32;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] rexp;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_sum",  sum4,  32'h0);
    check("rst_cout", cout4, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of an add
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_pre", busy4, 1'b1);
    check("mid_sum_pre",  sum4,  32'h0000_0FFF);
    rst_n = 1'b0;
    #1;
    check("mid_busy", busy4, 1'b0);
    check("mid_done", done4, 1'b0);
    check("mid_sum",  sum4,  32'h0);
    check("mid_cout", cout4, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done4) npulse++;
    end
    check("mid_no_done", npulse, 0);

    // Small add: latency and single-cycle done
    run_add(32'h0000_0005, 32'h0000_0003, 1'b0, lat);
    check("add_lat",  lat,   8);
    check("add_sum",  sum4,  32'h0000_0008);
    check("add_cout", cout4, 1'b0);
    check("add_busy", busy4, 1'b0);
`ifdef ADDER_OVERFLOW_FLAG_EN
    check("add_ovf", ovf4, 1'b0);
`endif
    @(posedge clk); #1;
    check("add_done_pulse", done4, 1'b0);
    check("add_sum_hold",   sum4,  32'h0000_0008);

    // Carry rippling through every digit
    run_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, lat);
    check("rip_lat",  lat,   8);
    check("rip_sum",  sum4,  32'h0);
    check("rip_cout", cout4, 1'b1);

    // Signed overflow boundary
    run_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("ovf_sum",  sum4,  32'h8000_0000);
    check("ovf_cout", cout4, 1'b0);
`ifdef ADDER_OVERFLOW_FLAG_EN
    check("ovf_flag", ovf4, 1'b1);
`endif

    // start held high and a changed mid-run
    a = 32'd10; b = 32'd20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    busy_ok = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 2) a = 32'hFFFF_0000;
      @(posedge clk); #1;
      if (done4) begin
        start = 1'b0;
        lat = i;
        break;
      end
      if (!busy4) busy_ok = 1'b0;
    end
    start = 1'b0;
    check("hold_busy", busy_ok, 1'b1);
    check("hold_lat",  lat,     8);
    check("hold_sum",  sum4,    32'd30);

    // Back-to-back issue from the done cycle
    run_add(32'd3, 32'd4, 1'b0, lat);
    check("b2b_first_sum", sum4, 32'd7);
    a = 32'd1; b = 32'd1; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_drop", done4, 1'b0);
    check("b2b_busy",      busy4, 1'b1);
    check("b2b_sum_clr",   sum4,  32'h0);
    wait_done(lat);
    check("b2b_lat", lat,  8);
    check("b2b_sum", sum4, 32'd2);

    // Let every instance drain before the random phase
    repeat (40) @(posedge clk);
    #1;

    // Random vectors on BPC = 1, 4, 32
    for (int v = 0; v < 1000; v++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
      a = ra; b = rb; cin = rc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s1 = 1'b0; s4 = 1'b0; s32 = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (done1)  s1  = 1'b1;
        if (done4)  s4  = 1'b1;
        if (done32) s32 = 1'b1;
        if (s1 && s4 && s32) break;
      end
      check("rnd_idle", {s1, s4, s32, busy1, busy4, busy32}, 6'b111000);
      check("rnd_bpc1",  {cout1,  sum1},  rexp);
      check("rnd_bpc4",  {cout4,  sum4},  rexp);
      check("rnd_bpc32", {cout32, sum32}, rexp);
`ifdef ADDER_OVERFLOW_FLAG_EN
      check("rnd_ovf", {ovf1, ovf4, ovf32},
            {3{(ra[31] == rb[31]) && (rexp[31] != ra[31])}});
`endif
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
